// File: rtl/wt_mem_arbiter.sv
// Memory arbiter for the write-through cache subsystem.
// Grants I$/D$ requests round robin into a single output register, limits
// in-flight requests per source, and routes registered returns back by tag.
module wt_mem_arbiter #(
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned RtrnWidth      = 128,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   // instruction cache request
   input  logic                 icache_data_req_i,
   output logic                 icache_data_ack_o,
   input  logic [DataWidth-1:0] icache_data_i,
   // data cache request
   input  logic                 dcache_data_req_i,
   output logic                 dcache_data_ack_o,
   input  logic [DataWidth-1:0] dcache_data_i,
   // memory request
   output logic                 mem_req_valid_o,
   input  logic                 mem_req_ready_i,
   output logic [DataWidth-1:0] mem_req_data_o,
   output logic                 mem_req_src_o,
   // memory return
   input  logic                 mem_rtrn_valid_i,
   input  logic                 mem_rtrn_src_i,
   input  logic [RtrnWidth-1:0] mem_rtrn_data_i,
   // returns to the caches
   output logic                 icache_rtrn_vld_o,
   output logic [RtrnWidth-1:0] icache_rtrn_o,
   output logic                 dcache_rtrn_vld_o,
   output logic [RtrnWidth-1:0] dcache_rtrn_o,
   output logic                 rtrn_err_o
);

   localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
   localparam int unsigned SumWidth = CntWidth + 1;
   localparam logic        SrcI     = 1'b0;
   localparam logic        SrcD     = 1'b1;

   // output request register
   logic                 req_vld_q;
   logic [DataWidth-1:0] req_data_q;
   logic                 req_src_q;
   logic                 last_gnt_q;

   // outstanding tracking
   logic [CntWidth-1:0]  cnt_i_q, cnt_d_q;
   logic [CntWidth-1:0]  cnt_i_d, cnt_d_d;
   logic                 err_q;

   // return registers
   logic                 ivld_q, dvld_q;
   logic [RtrnWidth-1:0] irtrn_q, drtrn_q;

   // arbitration signals
   logic                 pend_i, pend_d;
   logic                 elig_i, elig_d;
   logic                 can_load;
   logic                 gnt_i, gnt_d;

   // counter update signals
   logic                 fire;
   logic                 inc_i, inc_d;
   logic                 rtrn_i, rtrn_d;
   logic                 dec_i, dec_d;
   logic                 bad_rtrn;

   // eligibility and round-robin grant; no grant can happen during reset
   always_comb begin
      pend_i   = req_vld_q && (req_src_q == SrcI);
      pend_d   = req_vld_q && (req_src_q == SrcD);
      elig_i   = icache_data_req_i &&
                 ((SumWidth'(cnt_i_q) + SumWidth'(pend_i)) < SumWidth'(MaxOutstanding));
      elig_d   = dcache_data_req_i &&
                 ((SumWidth'(cnt_d_q) + SumWidth'(pend_d)) < SumWidth'(MaxOutstanding));
      can_load = !req_vld_q || mem_req_ready_i;
      gnt_i    = 1'b0;
      gnt_d    = 1'b0;
      if (!rst_i && can_load) begin
         if (elig_i && elig_d) begin
            if (last_gnt_q == SrcD) begin
               gnt_i = 1'b1;
            end else begin
               gnt_d = 1'b1;
            end
         end else if (elig_i) begin
            gnt_i = 1'b1;
         end else if (elig_d) begin
            gnt_d = 1'b1;
         end
      end
   end

   assign icache_data_ack_o = gnt_i;
   assign dcache_data_ack_o = gnt_d;

   // outstanding counters: issue increments, return decrements, never below zero
   always_comb begin
      fire     = req_vld_q && mem_req_ready_i;
      inc_i    = fire && (req_src_q == SrcI);
      inc_d    = fire && (req_src_q == SrcD);
      rtrn_i   = mem_rtrn_valid_i && (mem_rtrn_src_i == SrcI);
      rtrn_d   = mem_rtrn_valid_i && (mem_rtrn_src_i == SrcD);
      dec_i    = rtrn_i && (cnt_i_q != '0);
      dec_d    = rtrn_d && (cnt_d_q != '0);
      bad_rtrn = (rtrn_i && (cnt_i_q == '0)) || (rtrn_d && (cnt_d_q == '0));
      cnt_i_d  = cnt_i_q;
      cnt_d_d  = cnt_d_q;
      if (inc_i && !dec_i) begin
         cnt_i_d = cnt_i_q + CntWidth'(1);
      end else if (dec_i && !inc_i) begin
         cnt_i_d = cnt_i_q - CntWidth'(1);
      end
      if (inc_d && !dec_d) begin
         cnt_d_d = cnt_d_q + CntWidth'(1);
      end else if (dec_d && !inc_d) begin
         cnt_d_d = cnt_d_q - CntWidth'(1);
      end
   end

   // request register: load on grant, drain when the memory side accepts
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_vld_q  <= 1'b0;
         req_data_q <= '0;
         req_src_q  <= SrcI;
         last_gnt_q <= SrcD;
      end else if (gnt_i || gnt_d) begin
         req_vld_q  <= 1'b1;
         req_data_q <= gnt_i ? icache_data_i : dcache_data_i;
         req_src_q  <= gnt_d;
         last_gnt_q <= gnt_d;
      end else if (mem_req_ready_i) begin
         req_vld_q  <= 1'b0;
      end
   end

   // outstanding counters and sticky return error
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_i_q <= '0;
         cnt_d_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_i_q <= cnt_i_d;
         cnt_d_q <= cnt_d_d;
         if (bad_rtrn) begin
            err_q <= 1'b1;
         end
      end
   end

   // registered return routing; payload holds when no return for that cache
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ivld_q  <= 1'b0;
         dvld_q  <= 1'b0;
         irtrn_q <= '0;
         drtrn_q <= '0;
      end else begin
         ivld_q <= rtrn_i;
         dvld_q <= rtrn_d;
         if (rtrn_i) begin
            irtrn_q <= mem_rtrn_data_i;
         end
         if (rtrn_d) begin
            drtrn_q <= mem_rtrn_data_i;
         end
      end
   end

   assign mem_req_valid_o   = req_vld_q;
   assign mem_req_data_o    = req_data_q;
   assign mem_req_src_o     = req_src_q;
   assign icache_rtrn_vld_o = ivld_q;
   assign icache_rtrn_o     = irtrn_q;
   assign dcache_rtrn_vld_o = dvld_q;
   assign dcache_rtrn_o     = drtrn_q;
   assign rtrn_err_o        = err_q;

endmodule

// File: doc/wt_mem_arbiter.md
WT_MEM_ARBITER -- requirements
Module: wt_mem_arbiter

Interface
REQ-001 Parameter: DataWidth, default 64, width of request payload from each cache.
REQ-002 Parameter: RtrnWidth, default 128, width of return payload from memory.
REQ-003 Parameter: MaxOutstanding, default 4, maximum in-flight requests per source; counter width is clog2(MaxOutstanding+1).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have the following ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  async active-high reset
- icache_data_req_i  in  1  I$ request pending
- icache_data_ack_o  out  1  I$ request accepted (1-cycle pulse)
- icache_data_i  in  DataWidth  I$ request payload
- dcache_data_req_i  in  1  D$ request pending
- dcache_data_ack_o  out  1  D$ request accepted (1-cycle pulse)
- dcache_data_i  in  DataWidth  D$ request payload
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory side accepts request
- mem_req_data_o  out  DataWidth  memory request payload
- mem_req_src_o  out  1  source tag: 0=I$, 1=D$
- mem_rtrn_valid_i  in  1  memory return valid (no backpressure)
- mem_rtrn_src_i  in  1  return source tag
- mem_rtrn_data_i  in  RtrnWidth  return payload
- icache_rtrn_vld_o  out  1  return to I$ valid
- icache_rtrn_o  out  RtrnWidth  return payload to I$
- dcache_rtrn_vld_o  out  1  return to D$ valid
- dcache_rtrn_o  out  RtrnWidth  return payload to D$
- rtrn_err_o  out  1  sticky: return received for source with zero outstanding

Function
REQ-006 Requester SHALL hold req high with stable payload until ack; ack is combinational in the capture cycle.
REQ-007 The block SHALL hold one output register (valid, data, src); the register can capture when empty, or when full and mem_req_ready_i=1 in the same cycle.
REQ-008 A source is eligible when its req=1 and its outstanding count plus pending registered entry for that source < MaxOutstanding.
REQ-009 One eligible source: grant it; both eligible: grant the source not granted last (round robin); none: no capture.
REQ-010 On grant, the block SHALL assert exactly one ack, load payload/src into the register, and update the last-granted pointer.
REQ-011 mem_req_valid_o SHALL equal register-valid; data/src SHALL be stable while valid=1 and ready=0.
REQ-012 Per-source counter SHALL increment on mem_req_valid_o&mem_req_ready_i for that src and decrement on mem_rtrn_valid_i for that src; both in the same cycle leaves it unchanged.
REQ-013 Return path SHALL be registered: *_rtrn_vld_o pulses exactly 1 cycle after mem_rtrn_valid_i, routed by mem_rtrn_src_i, with payload captured that cycle; the other vld stays 0.
REQ-014 Return payload registers SHALL hold their value when no return is valid.
REQ-015 A return for a source whose counter is 0 SHALL set rtrn_err_o (sticky until reset), still be forwarded, and leave the counter at 0.
REQ-016 Full-throughput: with ready=1 continuously, one request per cycle SHALL be issued, alternating sources when both request.

Reset
REQ-017 While rst_i=1: all outputs 0, output register empty, both counters 0, rtrn_err_o 0, last-granted pointer = D$ (I$ wins the first tie).
REQ-018 Assertion of rst_i mid-transaction SHALL discard the registered request and counters immediately; no ack is issued while rst_i=1.

Verification
REQ-019 Both req high from reset, ready=1 -> I$ ack cycle 0, D$ ack cycle 1, mem_req_src_o sequence 0,1,0,1.
REQ-020 D$ req only, ready=0 for 5 cycles -> one D$ ack, mem_req_valid_o=1 with stable data; no second ack until ready=1.
REQ-021 I$ issues 4 requests, no returns (MaxOutstanding=4) -> 5th I$ req not acked; D$ still acked; one I$ return -> I$ acked next eligible cycle.
REQ-022 mem_rtrn_valid_i=1, src=1, data=0xA5.. -> dcache_rtrn_vld_o=1 next cycle with same data, icache_rtrn_vld_o=0.
REQ-023 Return src=0 with I$ counter 0 -> rtrn_err_o=1 and stays 1; icache_rtrn_vld_o still pulses.
REQ-024 rst_i asserted with full register and counters 2/3 -> all outputs 0 and counters 0 within the same cycle; after release, I$ wins first tie.
